// File: rtl/bit_serial_subtractor_pkg.sv
// bit_serial_subtractor_pkg: FSM state encoding and default operand width
package bit_serial_subtractor_pkg;
   localparam int WIDTH_DEF = 8;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/bit_serial_subtractor_if.sv
// bit_serial_subtractor_if: request/result bundle of the bit-serial subtractor
interface bit_serial_subtractor_if #(parameter int WIDTH = bit_serial_subtractor_pkg::WIDTH_DEF);
   logic start, bin, busy, done, bout, zero, ovf;
   logic [WIDTH-1:0] a, b, diff;
   modport master(output start, a, b, bin, input busy, done, diff, bout, zero, ovf);
   modport slave(input start, a, b, bin, output busy, done, diff, bout, zero, ovf);
endinterface

// File: rtl/bit_serial_subtractor_full_sub.sv
// full_sub: 1-bit full subtractor stage, diff = a - b - c with borrow out
module full_sub (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic diff,
   output logic br
);
   assign diff = a ^ b ^ c;
   assign br = (~a & b) | (~(a ^ b) & c);
endmodule

// File: rtl/bit_serial_subtractor.sv
// bit_serial_subtractor: LSB-first serial a - b - bin through one reused full_sub stage
module bit_serial_subtractor
   import bit_serial_subtractor_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input logic clk,
   input logic rst_n,
   bit_serial_subtractor_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   state_t state, state_nx;
   logic [WIDTH-1:0] sa, sb, res, diff_q, res_fin;
   logic [CW-1:0] cnt;
   logic br, d, br_nx, bout_q, zero_q, ovf_q, last;
   full_sub u_fs (.a(sa[0]), .b(sb[0]), .c(br), .diff(d), .br(br_nx));
   assign last = cnt == CW'(WIDTH - 1);
   assign res_fin = {d, res[WIDTH-1:1]};
   always_comb begin
      state_nx = state == IDLE  ? (bus.start ? SHIFT : IDLE) :
                 state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
   end
   // On the last SHIFT cycle sa[0]/sb[0] still hold the operand MSBs, so ovf needs no extra storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sa <= '0;
         sb <= '0;
         res <= '0;
         br <= 1'b0;
         cnt <= '0;
         diff_q <= '0;
         bout_q <= 1'b0;
         zero_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && bus.start) begin
            sa <= bus.a;
            sb <= bus.b;
            br <= bus.bin;
            cnt <= '0;
         end else if (state == SHIFT) begin
            sa <= sa >> 1;
            sb <= sb >> 1;
            res <= res_fin;
            br <= br_nx;
            cnt <= cnt + 1'b1;
            if (last) begin
               diff_q <= res_fin;
               bout_q <= br_nx;
               zero_q <= res_fin == '0;
               ovf_q <= (sa[0] != sb[0]) && (d != sa[0]);
            end
         end
      end
   end
   assign bus.busy = state == SHIFT;
   assign bus.done = state == DONE;
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
   assign bus.zero = zero_q;
   assign bus.ovf = ovf_q;
endmodule

// File: doc/bit_serial_subtractor.md
BIT_SERIAL_SUBTRACTOR -- requirements
Module: bit_serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; captured on the accepted start edge.
REQ-006 b  input  WIDTH  subtrahend; captured on the accepted start edge.
REQ-007 bin  input  1  borrow-in; captured on the accepted start edge.
REQ-008 busy  output  1  high while a subtraction is in progress (SHIFT state).
REQ-009 done  output  1  one-cycle pulse: result outputs updated.
REQ-010 diff  output  WIDTH  registered result a - b - bin, modulo 2^WIDTH.
REQ-011 bout  output  1  registered borrow-out of the MSB stage.
REQ-012 zero  output  1  registered flag, diff == 0.
REQ-013 ovf  output  1  registered two's-complement overflow flag.

Function
REQ-014 FSM states: IDLE, SHIFT, DONE; reset state IDLE.
REQ-015 IDLE: start=1 -> capture a, b, bin into internal shift registers; clear bit counter; go to SHIFT. start=0 -> stay.
REQ-016 SHIFT: each cycle, feed LSBs of the a/b shift registers plus the borrow register to one 1-bit full-subtract stage. Stage diff bit enters the MSB of the result shift register, which shifts right. Stage borrow replaces the borrow register. The a/b shift registers shift right. The counter increments.
REQ-017 Bit i (LSB first) is processed on the (i+1)-th edge after the start-accept edge. After the WIDTH-th bit, go to DONE.
REQ-018 On the DONE-entry edge, diff, bout, zero and ovf are loaded together from the completed result.
REQ-019 Load values: bout = final borrow; zero = (result == 0); ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
REQ-020 ovf ignores bin as a separate term; bin only affects diff.
REQ-021 done = 1 exactly while in DONE, one cycle. DONE then goes unconditionally to IDLE.
REQ-022 Latency: done is high in the cycle beginning WIDTH edges after the start-accept edge.
REQ-023 Throughput: a new start is accepted no earlier than WIDTH+2 edges after the previous accept.
REQ-024 busy = 1 exactly in SHIFT, never in IDLE or DONE.
REQ-025 start in SHIFT or DONE is ignored: no queueing, no effect on the operation in progress.
REQ-026 Changes to a, b or bin after the accept edge do not affect the operation in progress.
REQ-027 diff, bout, zero and ovf hold their last values from DONE until the next DONE entry; they never show partial results.
REQ-028 Counter width is clog2(WIDTH)+1 bits; the counter never wraps during an operation.

Reset
REQ-029 rst_n low asynchronously forces: state IDLE; busy=0; done=0; diff=0; bout=0; zero=0; ovf=0. Internal shift registers, borrow register and counter are also cleared.
REQ-030 Reset mid-SHIFT aborts the operation: no done pulse, outputs cleared. After release, the first start is accepted normally.
REQ-031 Reset deassertion needs no synchronous-release logic inside this block.

Structure
REQ-032 A shared package holds the FSM state enum and the default WIDTH constant.
REQ-033 Exactly one sub-module: a single full_sub instance (inputs a, b, c; outputs diff, br) forms the 1-bit stage. It is reused every SHIFT cycle; no other arithmetic datapath.

Verification
REQ-034 WIDTH=8, a=0x05, b=0x03, bin=0, start pulse -> done 8 cycles after accept; diff=0x02, bout=0, zero=0, ovf=0.
REQ-035 a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, zero=0, ovf=0.
REQ-036 a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Also a=0x37, b=0x37, bin=0 -> diff=0x00, zero=1, bout=0.
REQ-037 a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, zero=0, ovf=0.
REQ-038 Start held high continuously for 40 cycles with operands changing every cycle. Required: one accept per WIDTH+2 cycles; each result matches the operands captured at its accept edge; busy never drops mid-operation.
REQ-039 Assert rst_n low at bit 4 of an operation -> outputs 0 immediately, no done pulse. A following start with a=0x10, b=0x01 -> diff=0x0F, bout=0.
